// File: rtl/load_store_pkg.sv
// Shared types and helpers for the load/store ramp channels.
package load_store_pkg;

  typedef enum logic [1:0] {LS_TRI, LS_FILL, LS_DRAIN, LS_HOLD} ls_mode_t;

  // Effective limit: the runtime limit never exceeds the hard ceiling.
  function automatic logic [31:0] ls_clamp(input logic [31:0] lim, input logic [31:0] nmax);
    return (lim > nmax) ? nmax : lim;
  endfunction

endpackage

// File: rtl/load_store_ch.sv
// One load/store ramp channel: level, direction and registered full/empty flags.
// Flags are computed from the level being written, so they align with vol.
module load_store_ch
  import load_store_pkg::*;
#(
  parameter int CBITS = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  ls_mode_t         mode,
  input  logic [CBITS-1:0] lim,
  output logic [CBITS-1:0] vol,
  output logic             dir,
  output logic             full,
  output logic             empty,
  output logic             full_nxt
);

  localparam logic [CBITS:0] STEP_W = (CBITS+1)'(STEP);

  logic [CBITS:0]   v_w, l_w, up_w, dn_w;
  logic [CBITS-1:0] up_v, dn_v, vol_nxt;
  logic             dir_nxt, empty_nxt;

  // One spare bit so vol+STEP cannot wrap before the compare.
  assign v_w  = {1'b0, vol};
  assign l_w  = {1'b0, lim};
  assign up_w = v_w + STEP_W;
  assign dn_w = v_w - STEP_W;
  assign up_v = (up_w > l_w) ? lim : up_w[CBITS-1:0];
  assign dn_v = (v_w < STEP_W) ? '0 : dn_w[CBITS-1:0];

  always_comb begin
    vol_nxt   = vol;
    dir_nxt   = dir;
    full_nxt  = full;
    empty_nxt = empty;
    if (en) begin
      if (mode != LS_HOLD && vol > lim) begin
        // Limit dropped under the level: snap to it; only FILL keeps counting up.
        vol_nxt = lim;
        dir_nxt = (mode == LS_FILL);
      end else begin
        case (mode)
          LS_TRI: begin
            if (dir && vol >= lim) begin
              dir_nxt = 1'b0;
            end else if (dir) begin
              vol_nxt = up_v;
            end else if (vol == '0) begin
              dir_nxt = 1'b1;
            end else begin
              vol_nxt = dn_v;
            end
          end
          LS_FILL: begin
            dir_nxt = 1'b1;
            vol_nxt = up_v;
          end
          LS_DRAIN: begin
            dir_nxt = 1'b0;
            vol_nxt = dn_v;
          end
          default: ;
        endcase
      end
      full_nxt  = (vol_nxt >= lim);
      empty_nxt = (vol_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vol   <= '0;
      dir   <= 1'b0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      vol   <= vol_nxt;
      dir   <= dir_nxt;
      full  <= full_nxt;
      empty <= empty_nxt;
    end
  end

endmodule

// File: rtl/load_store_multi.sv
// NCH independent load/store ramp channels sharing one clamped runtime limit.
// any_full is registered alongside the per-channel flags (same-edge view).
module load_store_multi
  import load_store_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CBITS = 16,
  parameter int N_MAX = 50000,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [2*NCH-1:0]     mode,
  input  logic [CBITS-1:0]     lim,
  output logic [NCH*CBITS-1:0] vol,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       empty,
  output logic [NCH-1:0]       dir,
  output logic                 any_full
);

  logic [CBITS-1:0] lim_eff;
  logic [NCH-1:0]   full_nxt;

  assign lim_eff = CBITS'(ls_clamp(32'(lim), 32'(N_MAX)));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    load_store_ch #(
      .CBITS (CBITS),
      .STEP  (STEP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .mode     (ls_mode_t'(mode[2*i +: 2])),
      .lim      (lim_eff),
      .vol      (vol[CBITS*i +: CBITS]),
      .dir      (dir[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .full_nxt (full_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) any_full <= 1'b0;
    else     any_full <= |full_nxt;
  end

endmodule

// File: tb/tb_load_store_multi.sv
// Drives two copies of load_store_multi (STEP=1 and STEP=7) with directed and
// random stimulus, checking every output against an integer reference model.
module tb_load_store_multi;

  localparam int NCH  = 4;
  localparam int CB   = 16;
  localparam int NMAX = 50000;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  en;
  logic [2*NCH-1:0] mode;
  logic [CB-1:0]   lim;

  logic [NCH*CB-1:0] vol_a, vol_b;
  logic [NCH-1:0]    full_a, empty_a, dir_a, full_b, empty_b, dir_b;
  logic              any_a, any_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: [dut][channel]; dut 0 has STEP=1, dut 1 has STEP=7.
  int mv [2][NCH];
  bit md [2][NCH];
  bit mf [2][NCH];
  bit me [2][NCH];
  bit ma [2];

  always #5 clk = ~clk;

  load_store_multi #(.NCH(NCH), .CBITS(CB), .N_MAX(NMAX), .STEP(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lim(lim),
    .vol(vol_a), .full(full_a), .empty(empty_a), .dir(dir_a), .any_full(any_a)
  );

  load_store_multi #(.NCH(NCH), .CBITS(CB), .N_MAX(NMAX), .STEP(7)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lim(lim),
    .vol(vol_b), .full(full_b), .empty(empty_b), .dir(dir_b), .any_full(any_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int step_of(int k);
    return (k == 0) ? 1 : 7;
  endfunction

  function automatic logic [CB-1:0] dvol(int k, int i);
    return (k == 0) ? vol_a[CB*i +: CB] : vol_b[CB*i +: CB];
  endfunction

  function automatic logic [3:0] dflags(int k, int i);
    // {dir, full, empty, any_full}
    return (k == 0) ? {dir_a[i], full_a[i], empty_a[i], any_a}
                    : {dir_b[i], full_b[i], empty_b[i], any_b};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NCH; i++) begin
        mv[k][i] = 0; md[k][i] = 0; mf[k][i] = 0; me[k][i] = 1;
      end
      ma[k] = 0;
    end
  endtask

  task automatic model_step(input bit r, input logic [NCH-1:0] e,
                            input logic [2*NCH-1:0] m, input int l);
    int lv, v, s, nv, md_i;
    bit d, nd;
    if (r) begin
      model_reset();
      return;
    end
    lv = (l > NMAX) ? NMAX : l;
    for (int k = 0; k < 2; k++) begin
      s = step_of(k);
      for (int i = 0; i < NCH; i++) begin
        if (!e[i]) continue;
        v = mv[k][i]; d = md[k][i]; md_i = int'(m[2*i +: 2]);
        nv = v; nd = d;
        if (md_i != 3) begin
          if (v > lv) begin
            nv = lv;
            nd = (md_i == 1);
          end else if (md_i == 1 || (md_i == 0 && d && v < lv)) begin
            nv = (v + s > lv) ? lv : v + s;
            nd = 1;
          end else if (md_i == 2 || (md_i == 0 && !d && v > 0)) begin
            nv = (v < s) ? 0 : v - s;
            nd = 0;
          end else begin
            nd = !d;  // TRI turnaround at either end, no count
          end
        end
        mv[k][i] = nv; md[k][i] = nd;
        mf[k][i] = (nv >= lv); me[k][i] = (nv == 0);
      end
      ma[k] = 0;
      for (int i = 0; i < NCH; i++) ma[k] |= mf[k][i];
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NCH; i++) begin
        check($sformatf("%s d%0d c%0d vol", tag, k, i), 64'(dvol(k, i)), 64'(mv[k][i]));
        check($sformatf("%s d%0d c%0d flags", tag, k, i), 64'(dflags(k, i)),
              64'({md[k][i], mf[k][i], me[k][i], ma[k]}));
      end
    end
  endtask

  task automatic tick(input string tag);
    bit               r = rst;
    logic [NCH-1:0]   e = en;
    logic [2*NCH-1:0] m = mode;
    int               l = int'(lim);
    @(posedge clk);
    #1;
    model_step(r, e, m, l);
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick("rst");
    rst = 1'b0;
  endtask

  initial begin
    int seq1 [10] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
    int seq3 [9]  = '{0, 7, 14, 20, 20, 13, 6, 0, 0};
    logic [CB-1:0] snap;

    model_reset();
    rst = 1'b1; en = '0; mode = '0; lim = '0;
    tick("rst0");
    tick("rst1");
    check("reset vol", 64'(vol_a), 64'(0));
    check("reset empty", 64'(empty_a), 64'(4'hF));
    check("reset full/dir/any", 64'({full_a, dir_a, any_a}), 64'(0));
    rst = 1'b0;

    // TRI triangle with lim=3 on ch0 (STEP=1)
    en = 4'b0001; mode = '0; lim = 16'd3;
    for (int c = 0; c < 10; c++) begin
      tick("t1");
      check($sformatf("t1 vol[%0d]", c), 64'(vol_a[CB-1:0]), 64'(seq1[c]));
      check($sformatf("t1 full[%0d]", c), 64'(full_a[0]), 64'(seq1[c] == 3));
      check($sformatf("t1 empty[%0d]", c), 64'(empty_a[0]), 64'(seq1[c] == 0));
    end

    // STEP=7, lim=20 TRI on the second instance
    do_reset();
    lim = 16'd20;
    for (int c = 0; c < 9; c++) begin
      tick("t3");
      check($sformatf("t3 vol[%0d]", c), 64'(vol_b[CB-1:0]), 64'(seq3[c]));
    end

    // FILL past the ceiling: lim=60000 clamps to 50000
    do_reset();
    en = 4'b0001; mode = 8'b01; lim = 16'd60000;
    for (int c = 0; c < 7200; c++) tick("t2");
    check("t2 vol sat", 64'(vol_b[CB-1:0]), 64'(50000));
    check("t2 full", 64'({full_b[0], any_b}), 64'(2'b11));
    tick("t2hold");
    check("t2 vol held", 64'(vol_b[CB-1:0]), 64'(50000));

    // ch1 ramping up at 10, lim drops 40 -> 5
    do_reset();
    en = 4'b0010; mode = '0; lim = 16'd40;
    for (int c = 0; c < 11; c++) tick("t4ramp");
    check("t4 pre vol", 64'(vol_a[CB +: CB]), 64'(10));
    check("t4 pre dir", 64'(dir_a[1]), 64'(1));
    lim = 16'd5;
    tick("t4");
    check("t4 vol", 64'(vol_a[CB +: CB]), 64'(5));
    check("t4 full/dir", 64'({full_a[1], dir_a[1]}), 64'(2'b10));

    // ch0 TRI, ch1 HOLD, ch2 disabled, ch3 DRAIN from 0
    do_reset();
    en = 4'b1011; mode = {2'b10, 2'b00, 2'b11, 2'b00}; lim = 16'd2;
    snap = vol_a[CB +: CB];
    for (int c = 0; c < 8; c++) begin
      tick("t5");
      check("t5 ch1 vol", 64'(vol_a[CB +: CB]), 64'(snap));
      check("t5 ch3 empty", 64'({empty_a[3], vol_a[3*CB +: CB]}), 64'({1'b1, 16'd0}));
      check("t5 any", 64'(any_a), 64'(full_a[0]));
    end

    // Reset mid-ramp at 25, then lim=0 TRI
    do_reset();
    en = 4'b1111; mode = '0; lim = 16'd100;
    for (int c = 0; c < 26; c++) tick("t6ramp");
    check("t6 pre vol", 64'(vol_a[CB-1:0]), 64'(25));
    rst = 1'b1;
    tick("t6rst");
    check("t6 rst vol", 64'(vol_a), 64'(0));
    check("t6 rst dir/empty", 64'({dir_a, empty_a}), 64'(8'h0F));
    rst = 1'b0; lim = '0;
    for (int c = 0; c < 6; c++) begin
      tick("t6lim0");
      check("t6 full/empty", 64'({full_a, empty_a}), 64'(8'hFF));
      check("t6 dir", 64'(dir_a), (c % 2 == 0) ? 64'(4'hF) : 64'(0));
    end

    // Random mix of modes, enables, limits and occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = NCH'($urandom);
      mode = (2*NCH)'($urandom);
      if ($urandom_range(0, 15) == 0) lim = CB'($urandom);
      else if ($urandom_range(0, 3) == 0) lim = CB'($urandom_range(0, 40));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
